// File: rtl/zero_trig_qualifier.sv
// Per-channel trigger qualifier feeding the ZERO-window counters: applies enable,
// continuous/burst arming, holdoff and burst limit, and emits one registered pulse.
module zero_trig_qualifier #(
  parameter int POS_W   = 2,
  parameter int HOLD_W  = 32,
  parameter int BURST_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               data_clk_i,
  input  logic               data_rst_n_i,
  input  logic               enable_i,
  input  logic               mode_i,
  input  logic               arm_i,
  input  logic [HOLD_W-1:0]  holdoff_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               clr_cnt_i,
  input  logic               trig_rise_i,
  input  logic [POS_W-1:0]   trig_pos_i,
  output logic               qual_trig_o,
  output logic [POS_W-1:0]   qual_pos_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   accepted_cnt_o,
  output logic [CNT_W-1:0]   rejected_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               mode_q;
  logic               qual_trig_q;
  logic [POS_W-1:0]   qual_pos_q;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   rej_cnt_q, rej_cnt_d;

  logic               rearm;
  logic               accept;
  logic               reject;
  logic [BURST_W:0]   burst_inc;
  logic [BURST_W:0]   burst_lim;
  logic               burst_hit;

  // mode_q remembers whether the channel was armed in burst mode, so a stray arm_i
  // in continuous operation never aborts holdoff or steals a trigger.
  always_comb begin
    rearm     = enable_i && arm_i &&
                ((state_q == S_DONE) ||
                 (((state_q == S_ARMED) || (state_q == S_HOLD)) && mode_q));
    accept    = enable_i && trig_rise_i && (state_q == S_ARMED) && !rearm;
    reject    = enable_i && trig_rise_i && (state_q != S_IDLE) && !accept;
    burst_inc = {1'b0, burst_cnt_q} + {{BURST_W{1'b0}}, 1'b1};
    burst_lim = (burst_len_i == '0) ? {{BURST_W{1'b0}}, 1'b1} : {1'b0, burst_len_i};
    burst_hit = mode_i && (burst_inc >= burst_lim);
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (clr_cnt_i) begin
      acc_cnt_d = '0;
      rej_cnt_d = '0;
    end else begin
      if (accept && (acc_cnt_q != '1)) acc_cnt_d = acc_cnt_q + 1'b1;
      if (reject && (rej_cnt_q != '1)) rej_cnt_d = rej_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge data_clk_i or negedge data_rst_n_i) begin
    if (!data_rst_n_i) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  always_ff @(posedge data_clk_i or negedge data_rst_n_i) begin
    if (!data_rst_n_i) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      burst_cnt_q <= '0;
      mode_q      <= 1'b0;
      qual_trig_q <= 1'b0;
      qual_pos_q  <= '0;
    end else begin
      qual_trig_q <= accept;
      if (accept) qual_pos_q <= trig_pos_i;
      if (!enable_i) begin
        state_q    <= S_IDLE;
        hold_cnt_q <= '0;
      end else if (rearm) begin
        state_q     <= S_ARMED;
        burst_cnt_q <= '0;
        hold_cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!mode_i) begin
              state_q <= S_ARMED;
              mode_q  <= 1'b0;
            end else if (arm_i) begin
              state_q     <= S_ARMED;
              mode_q      <= 1'b1;
              burst_cnt_q <= '0;
            end
          end
          S_ARMED: begin
            if (accept) begin
              hold_cnt_q <= holdoff_i;
              mode_q     <= mode_i;
              if (mode_i) burst_cnt_q <= burst_inc[BURST_W-1:0];
              if (burst_hit)            state_q <= S_DONE;
              else if (holdoff_i != '0) state_q <= S_HOLD;
            end
          end
          S_HOLD: begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
            if (hold_cnt_q <= {{(HOLD_W-1){1'b0}}, 1'b1}) state_q <= S_ARMED;
          end
          default: ;
        endcase
      end
    end
  end

  assign qual_trig_o    = qual_trig_q;
  assign qual_pos_o     = qual_pos_q;
  assign state_o        = state_q;
  assign accepted_cnt_o = acc_cnt_q;
  assign rejected_cnt_o = rej_cnt_q;

endmodule

// File: tb/tb_zero_trig_qualifier.sv
// Vector-table bench for zero_trig_qualifier with small counter/holdoff widths.
module tb_zero_trig_qualifier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, mode, arm, clr, trig;
  logic [7:0] holdoff;
  logic [3:0] burst_len;
  logic [1:0] trig_pos;
  logic       qual_trig;
  logic [1:0] qual_pos;
  logic [1:0] state;
  logic [3:0] acc_cnt, rej_cnt;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  zero_trig_qualifier #(.POS_W(2), .HOLD_W(8), .BURST_W(4), .CNT_W(4)) dut (
    .data_clk_i     (clk),
    .data_rst_n_i   (rst_n),
    .enable_i       (enable),
    .mode_i         (mode),
    .arm_i          (arm),
    .holdoff_i      (holdoff),
    .burst_len_i    (burst_len),
    .clr_cnt_i      (clr),
    .trig_rise_i    (trig),
    .trig_pos_i     (trig_pos),
    .qual_trig_o    (qual_trig),
    .qual_pos_o     (qual_pos),
    .state_o        (state),
    .accepted_cnt_o (acc_cnt),
    .rejected_cnt_o (rej_cnt)
  );

  typedef struct {
    logic       en, md, ar, tr, cl;
    logic [1:0] pos;
    logic [7:0] hold;
    logic [3:0] blen;
    logic       qt;
    logic [1:0] qp, st;
    logic [3:0] acc, rej;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(int en, int md, int ar, int tr, int pos, int cl, int hold,
                              int blen, int qt, int qp, int st, int acc, int rej);
    vec_t v;
    v.en = en[0]; v.md = md[0]; v.ar = ar[0]; v.tr = tr[0]; v.cl = cl[0];
    v.pos = 2'(pos); v.hold = 8'(hold); v.blen = 4'(blen);
    v.qt = qt[0]; v.qp = 2'(qp); v.st = 2'(st); v.acc = 4'(acc); v.rej = 4'(rej);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    enable = v.en; mode = v.md; arm = v.ar; trig = v.tr; clr = v.cl;
    trig_pos = v.pos; holdoff = v.hold; burst_len = v.blen;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("qual_trig", 32'(qual_trig), 32'(e.qt));
    chk("qual_pos",  32'(qual_pos),  32'(e.qp));
    chk("state",     32'(state),     32'(e.st));
    chk("accepted",  32'(acc_cnt),   32'(e.acc));
    chk("rejected",  32'(rej_cnt),   32'(e.rej));
  endtask

  initial begin
    rst_n = 1'b0; enable = 0; mode = 0; arm = 0; clr = 0; trig = 0;
    trig_pos = 0; holdoff = 0; burst_len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qual_trig", 32'(qual_trig), 0);
    chk("rst_state",     32'(state),     0);
    chk("rst_accepted",  32'(acc_cnt),   0);
    chk("rst_rejected",  32'(rej_cnt),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // continuous, holdoff 3, trigger every cycle
    vecs.push_back(mk(1,0,0,0,0,0,3,0, 0,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 1,0,2,1,0));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,2,1,1));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,2,1,2));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,1,1,3));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 1,0,2,2,3));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,2,2,4));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,2,2,5));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,1,2,6));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 1,0,2,3,6));
    vecs.push_back(mk(1,0,0,1,0,0,3,0, 0,0,2,3,7));
    // disable in holdoff with a trigger: idle, no count change
    vecs.push_back(mk(0,0,0,1,0,0,3,0, 0,0,0,3,7));
    vecs.push_back(mk(0,0,0,0,0,1,3,0, 0,0,0,0,0));
    // burst of 2, holdoff 0
    vecs.push_back(mk(1,1,0,0,0,0,0,2, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0,0,2, 0,0,1,0,0));
    vecs.push_back(mk(1,1,0,1,1,0,0,2, 1,1,1,1,0));
    vecs.push_back(mk(1,1,0,1,2,0,0,2, 1,2,3,2,0));
    for (int i = 1; i <= 3; i++) vecs.push_back(mk(1,1,0,1,0,0,0,2, 0,2,3,2,i));
    vecs.push_back(mk(1,1,1,0,0,0,0,2, 0,2,1,2,3));
    vecs.push_back(mk(1,1,0,1,3,0,0,2, 1,3,1,3,3));
    vecs.push_back(mk(1,1,1,1,0,0,0,2, 0,3,1,3,4));
    vecs.push_back(mk(1,1,0,1,0,0,0,2, 1,0,1,4,4));
    // re-arm aborting holdoff
    vecs.push_back(mk(1,1,1,0,0,0,5,2, 0,0,1,4,4));
    vecs.push_back(mk(1,1,0,1,1,0,5,2, 1,1,2,5,4));
    vecs.push_back(mk(1,1,1,0,0,0,5,2, 0,1,1,5,4));
    vecs.push_back(mk(1,1,0,1,2,0,5,2, 1,2,2,6,4));
    vecs.push_back(mk(0,0,0,0,0,1,0,0, 0,2,0,0,0));
    // continuous, holdoff 0, positions 0..3
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,2,1,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,1,i,0,0,0, 1,i,1,i+1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,3,1,4,0));
    vecs.push_back(mk(1,0,0,1,2,1,0,0, 1,2,1,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,0, 0,2,0,0,0));
    vecs.push_back(mk(1,1,0,1,1,0,0,0, 0,2,0,0,0));
    // burst_len 0 acts as 1, then rejected-count saturation
    vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,2,1,0,0));
    vecs.push_back(mk(1,1,0,1,1,0,0,0, 1,1,3,1,0));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1,1,0,1,0,0,0,0, 0,1,3,1,(i + 1 > 15) ? 15 : i + 1));
    vecs.push_back(mk(1,1,0,1,0,1,0,0, 0,1,3,0,0));
    // accepted-count saturation
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0,0));
    for (int i = 0; i < 17; i++)
      vecs.push_back(mk(1,0,0,1,i % 4,0,0,0, 1,i % 4,1,(i + 1 > 15) ? 15 : i + 1,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0, 0,0,0,0,0));

    foreach (vecs[k]) step(vecs[k]);

    // reset in the middle of a long holdoff
    step(mk(1,0,0,0,0,0,100,0, 0,0,1,0,0));
    step(mk(1,0,0,1,3,0,100,0, 1,3,2,1,0));
    repeat (10) step(mk(1,0,0,0,0,0,100,0, 0,3,2,1,0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_qual_trig", 32'(qual_trig), 0);
    chk("async_qual_pos",  32'(qual_pos),  0);
    chk("async_state",     32'(state),     0);
    chk("async_accepted",  32'(acc_cnt),   0);
    chk("async_rejected",  32'(rej_cnt),   0);
    @(posedge clk);
    #1;
    chk("held_rst_state", 32'(state), 0);
    @(negedge clk);
    enable = 0; trig = 0;
    rst_n = 1'b1;
    step(mk(0,0,0,0,0,0,100,0, 0,0,0,0,0));
    step(mk(1,0,0,1,2,0,100,0, 0,0,1,0,0));
    step(mk(1,0,0,1,2,0,100,0, 1,2,2,1,0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
